sos_ctrl_module: RTL and testbench
==================================

Name: sos_ctrl_module

Overview:
- Sequencer that sits directly upstream of the S-letter and O-letter generators in the SOS blinker.
- On a trigger pulse it drives the letter generators' level-held start inputs in the order S, O, S, with timed inter-letter and inter-word gaps, and repeats the word REPEAT times.
- Consumes each generator's one-cycle-registered done indication and reports overall completion, busy and watchdog error to the top level.

Parameters:
- T1MS, 16'd49_999, terminal count of the 1 ms prescaler (50 MHz CLK).
- GAP_MS, 10'd150, silent gap between letters, in ms.
- WORD_GAP_MS, 10'd350, silent gap between repeated words, in ms.
- REPEAT, 4'd2, number of SOS words per trigger; legal range 1..15.
- TIMEOUT_MS, 10'd1000, watchdog limit on any single letter, in ms.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset
- Trig_Sig  in  1  one-cycle start request from the key debounce stage
- S_Done_Sig  in  1  done from the S generator; may stay high while its start is low
- O_Done_Sig  in  1  done from the O generator; same semantics
- S_Start_Sig  out  1  level-held run enable to the S generator
- O_Start_Sig  out  1  level-held run enable to the O generator
- Busy_Sig  out  1  high from trigger acceptance until DONE or ERR
- Done_Sig  out  1  one-cycle pulse when all words are complete
- Err_Sig  out  1  sticky watchdog error flag

Behaviour:
- Clock and reset: clock CLK; reset RSTn, asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-operation: both starts drop immediately and the block returns to IDLE.
- All outputs are registered.
- States: IDLE, LS1, GAP1, LO, GAP2, LS2, WGAP, DONE, ERR.
- IDLE:
  - Trig_Sig=1 at edge k moves to LS1.
  - S_Start_Sig and Busy_Sig are high after edge k.
  - The word counter is cleared to 0.
  - Err_Sig is cleared at the same edge.
- Letter states (LS1, LO, LS2):
  - Hold the matching start high.
  - The done input is sampled only once the start has been high for at least 2 edges (blanking). The downstream generator can still present a stale done=1 from its previous run during the first cycle.
  - An unblanked done=1 at edge n: start low after edge n; move to the following gap state.
  - The watchdog resets on entry. Exceeding TIMEOUT_MS ms without done moves to ERR.
- Gap states (GAP1, GAP2, WGAP):
  - Both starts are low.
  - The prescaler and ms counter clear on entry.
  - The state exits after exactly GAP_MS (or WORD_GAP_MS) x (T1MS+1) cycles.
  - Transitions: GAP1 goes to LO; GAP2 goes to LS2.
  - After LS2: if word count+1 < REPEAT, increment the word count and go to WGAP, then to LS1. Otherwise go to DONE.
- DONE: Done_Sig=1 for one cycle; Busy_Sig low at the same edge; next state IDLE.
- ERR:
  - Both starts low; Busy_Sig low.
  - Err_Sig=1, held until the next accepted Trig_Sig.
  - Next state IDLE on the following cycle.
- Trig_Sig while busy is ignored and not queued.
- A done input arriving when its start is low is ignored. So is the other letter's done.
- S_Start_Sig and O_Start_Sig are never high together.
- Counter widths: the prescaler is 16 bit and wraps at T1MS; the ms counter is 10 bit and saturates. The watchdog reuses the ms counter.

Decomposition:
- Shared package holds the state encodings and the default timing constants T1MS, GAP_MS and TIMEOUT_MS. The same constants are used by the S and O generators.
- One sub-module is natural: ms_timer. It contains the clear-on-entry 1 ms prescaler plus the 10-bit ms counter, with a clear input and an ms_count output. The FSM stays in the top.

Test Plan:
Bench overrides: T1MS=9 (10 cycles/ms), GAP_MS=3, WORD_GAP_MS=5, TIMEOUT_MS=20, REPEAT=2. The letter generators are modelled as BFMs that raise done 40 cycles after start and hold it until the next start.
- Single run: Trig at cycle 10 -> S_Start high cycles 11..51. O_Start rises exactly 30 cycles after S_Start falls. The sequence S,O,S,(50-cycle gap),S,O,S follows. Done_Sig pulses once; Busy falls with it.
- Stale done: the S BFM holds done=1 from the previous run at the moment of the second S_Start -> no early completion; S_Start remains high the full 40 cycles.
- Trig while busy: Trig pulses during GAP1 and during LO -> ignored; total sequence length unchanged; exactly one Done_Sig.
- Watchdog: O BFM never asserts done -> O_Start drops after 200 cycles; Err_Sig=1, Busy=0. The next Trig clears Err and restarts at LS1.
- Reset mid-letter: RSTn low during LS2 -> S_Start, Busy and Done are 0 asynchronously. After release, no outputs change until a new Trig.
- REPEAT=1 rebuild: one S,O,S word only; no WGAP; Done_Sig follows LS2 completion by 1 cycle.

Source files
------------

// File: rtl/sos_ctrl_module_pkg.sv
// Shared definitions for the SOS blinker: sequencer state encoding and the
// default timing constants also used by the S and O letter generators.
package sos_ctrl_module_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LS1  = 4'd1,
        ST_GAP1 = 4'd2,
        ST_LO   = 4'd3,
        ST_GAP2 = 4'd4,
        ST_LS2  = 4'd5,
        ST_WGAP = 4'd6,
        ST_DONE = 4'd7,
        ST_ERR  = 4'd8
    } state_t;

    // Default timing for a 50 MHz system clock
    localparam logic [15:0] SOS_T1MS        = 16'd49_999;
    localparam logic [9:0]  SOS_GAP_MS      = 10'd150;
    localparam logic [9:0]  SOS_WORD_GAP_MS = 10'd350;
    localparam logic [3:0]  SOS_REPEAT      = 4'd2;
    localparam logic [9:0]  SOS_TIMEOUT_MS  = 10'd1000;

    // True for the states that drive a letter generator
    function automatic logic is_letter(input state_t st);
        return (st == ST_LS1) || (st == ST_LO) || (st == ST_LS2);
    endfunction

endpackage

// File: rtl/sos_ctrl_module_ms_timer.sv
// Millisecond timebase: a 16-bit prescaler wrapping at T1MS and a saturating
// 10-bit millisecond counter. Both restart from zero whenever clear is high.
module sos_ctrl_module_ms_timer
    import sos_ctrl_module_pkg::*;
#(
    parameter logic [15:0] T1MS = SOS_T1MS
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       clear,
    output logic       tick,
    output logic [9:0] ms_count
);

    logic [15:0] presc_reg;
    logic [9:0]  ms_reg;

    // tick marks the last cycle of each millisecond
    assign tick     = (presc_reg == T1MS);
    assign ms_count = ms_reg;

    // Prescaler and ms counter; clear has priority over counting
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_reg <= 16'd0;
            ms_reg    <= 10'd0;
        end else if (clear) begin
            presc_reg <= 16'd0;
            ms_reg    <= 10'd0;
        end else if (tick) begin
            presc_reg <= 16'd0;
            if (ms_reg != 10'h3FF) begin
                ms_reg <= ms_reg + 10'd1;
            end
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

endmodule

// File: rtl/sos_ctrl_module.sv
// SOS sequencer: on a trigger, runs the S, O, S letter generators with timed
// gaps, repeats the word REPEAT times, and reports busy, done and watchdog error.
module sos_ctrl_module
    import sos_ctrl_module_pkg::*;
#(
    parameter logic [15:0] T1MS        = SOS_T1MS,
    parameter logic [9:0]  GAP_MS      = SOS_GAP_MS,
    parameter logic [9:0]  WORD_GAP_MS = SOS_WORD_GAP_MS,
    parameter logic [3:0]  REPEAT      = SOS_REPEAT,
    parameter logic [9:0]  TIMEOUT_MS  = SOS_TIMEOUT_MS
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Trig_Sig,
    input  logic S_Done_Sig,
    input  logic O_Done_Sig,
    output logic S_Start_Sig,
    output logic O_Start_Sig,
    output logic Busy_Sig,
    output logic Done_Sig,
    output logic Err_Sig
);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] word_reg;
    logic [3:0] word_next;
    logic       armed_reg;
    logic       trig_accept;
    logic       timer_clear;
    logic       ms_tick;
    logic [9:0] ms_count;
    logic       gap_end;
    logic       wgap_end;
    logic       timeout;

    logic s_start_reg;
    logic o_start_reg;
    logic busy_reg;
    logic done_reg;
    logic err_reg;

    sos_ctrl_module_ms_timer #(
        .T1MS (T1MS)
    ) u_ms_timer (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .clear    (timer_clear),
        .tick     (ms_tick),
        .ms_count (ms_count)
    );

    // Interval ends land on the last cycle of the final millisecond, so a
    // gap lasts exactly N x (T1MS+1) cycles from entry.
    assign gap_end  = ms_tick && (ms_count == GAP_MS - 10'd1);
    assign wgap_end = ms_tick && (ms_count == WORD_GAP_MS - 10'd1);
    assign timeout  = ms_tick && (ms_count == TIMEOUT_MS - 10'd1);

    // Next-state logic; done inputs only count once the letter is armed
    always_comb begin
        state_next  = state_reg;
        word_next   = word_reg;
        trig_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Trig_Sig) begin
                    trig_accept = 1'b1;
                    word_next   = 4'd0;
                    state_next  = ST_LS1;
                end
            end
            ST_LS1: begin
                if (armed_reg && S_Done_Sig) begin
                    state_next = ST_GAP1;
                end else if (timeout) begin
                    state_next = ST_ERR;
                end
            end
            ST_GAP1: begin
                if (gap_end) begin
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                if (armed_reg && O_Done_Sig) begin
                    state_next = ST_GAP2;
                end else if (timeout) begin
                    state_next = ST_ERR;
                end
            end
            ST_GAP2: begin
                if (gap_end) begin
                    state_next = ST_LS2;
                end
            end
            ST_LS2: begin
                if (armed_reg && S_Done_Sig) begin
                    if (({1'b0, word_reg} + 5'd1) < {1'b0, REPEAT}) begin
                        word_next  = word_reg + 4'd1;
                        state_next = ST_WGAP;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else if (timeout) begin
                    state_next = ST_ERR;
                end
            end
            ST_WGAP: begin
                if (wgap_end) begin
                    state_next = ST_LS1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Restart the timebase on every state entry and hold it while idle
        timer_clear = (state_next != state_reg) || (state_reg == ST_IDLE);
    end

    // State, counters and registered outputs (outputs decoded from next state)
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= ST_IDLE;
            word_reg    <= 4'd0;
            armed_reg   <= 1'b0;
            s_start_reg <= 1'b0;
            o_start_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            // Cleared on entry, set one edge later: blanks a stale done
            armed_reg   <= (state_next == state_reg) && is_letter(state_reg);
            s_start_reg <= (state_next == ST_LS1) || (state_next == ST_LS2);
            o_start_reg <= (state_next == ST_LO);
            busy_reg    <= state_next inside {ST_LS1, ST_GAP1, ST_LO, ST_GAP2, ST_LS2, ST_WGAP};
            done_reg    <= (state_next == ST_DONE);
            if (state_next == ST_ERR) begin
                err_reg <= 1'b1;
            end else if (trig_accept) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign S_Start_Sig = s_start_reg;
    assign O_Start_Sig = o_start_reg;
    assign Busy_Sig    = busy_reg;
    assign Done_Sig    = done_reg;
    assign Err_Sig     = err_reg;

endmodule

// File: tb/tb_sos_ctrl_module.sv
// Bench for sos_ctrl_module: two instances (REPEAT=2 and REPEAT=1) driven by
// letter-generator BFMs; output changes are checked against a timed event plan.
module tb_sos_ctrl_module;

    // Durations derived from the bench timing: 10 cycles per ms, BFM done
    // after 40 cycles of start, sampled one edge later.
    localparam int LETTER_CYC = 41;
    localparam int GAP_CYC    = 3 * 10;
    localparam int WGAP_CYC   = 5 * 10;
    localparam int TOUT_CYC   = 20 * 10;

    // Output vector order: {S_Start, O_Start, Busy, Done, Err}
    localparam logic [4:0] V_SB   = 5'b10100;
    localparam logic [4:0] V_OB   = 5'b01100;
    localparam logic [4:0] V_B    = 5'b00100;
    localparam logic [4:0] V_DONE = 5'b00010;
    localparam logic [4:0] V_ERR  = 5'b00001;
    localparam logic [4:0] V_IDLE = 5'b00000;

    typedef struct packed {
        logic [0:0]  inst;
        logic [4:0]  vec;
        logic [31:0] cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trig [2];
    logic        o_hang [2];
    logic [4:0]  out_vec [2];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    ev_t         exp_q [$];
    ev_t         plan_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic       s_start, o_start, busy, done, err;
        logic       s_done = 1'b1;
        logic       o_done = 1'b0;
        logic [5:0] s_cnt = 6'd0;
        logic [5:0] o_cnt = 6'd0;

        sos_ctrl_module #(
            .T1MS        (16'd9),
            .GAP_MS      (10'd3),
            .WORD_GAP_MS (10'd5),
            .REPEAT      ((gi == 0) ? 4'd2 : 4'd1),
            .TIMEOUT_MS  (10'd20)
        ) u_dut (
            .CLK         (clk),
            .RSTn        (rstn),
            .Trig_Sig    (trig[gi]),
            .S_Done_Sig  (s_done),
            .O_Done_Sig  (o_done),
            .S_Start_Sig (s_start),
            .O_Start_Sig (o_start),
            .Busy_Sig    (busy),
            .Done_Sig    (done),
            .Err_Sig     (err)
        );

        assign out_vec[gi] = {s_start, o_start, busy, done, err};

        // S generator: done drops after the first started cycle, rises 40 cycles in, then holds
        always @(posedge clk) begin
            if (s_start) begin
                if (s_cnt == 6'd0)  s_done <= 1'b0;
                if (s_cnt == 6'd39) s_done <= 1'b1;
                if (s_cnt != 6'd40) s_cnt <= s_cnt + 6'd1;
            end else begin
                s_cnt <= 6'd0;
            end
        end

        // O generator: same behaviour, can be told never to finish
        always @(posedge clk) begin
            if (o_start) begin
                if (o_cnt == 6'd0) o_done <= 1'b0;
                if (o_cnt == 6'd39 && !o_hang[gi]) o_done <= 1'b1;
                if (o_cnt != 6'd40) o_cnt <= o_cnt + 6'd1;
            end else begin
                o_cnt <= 6'd0;
            end
        end
    end

    task automatic push_plan(input int inst, input int t, input logic [4:0] vec);
        ev_t e;
        e.inst = inst[0];
        e.vec  = vec;
        e.cyc  = t;
        plan_q.push_back(e);
    endtask

    // Reference plan: the timed list of output changes for one triggered run
    task automatic plan_run(input int inst, input int ta, input int reps, input bit hang);
        int t;
        t = ta;
        plan_q.delete();
        for (int w = 0; w < reps; w++) begin
            if (w > 0) t += WGAP_CYC;
            for (int l = 0; l < 3; l++) begin
                if (l > 0) t += GAP_CYC;
                push_plan(inst, t, (l == 1) ? V_OB : V_SB);
                if (l == 1 && hang) begin
                    push_plan(inst, t + TOUT_CYC, V_ERR);
                    return;
                end
                t += LETTER_CYC;
                if (w == reps - 1 && l == 2) begin
                    push_plan(inst, t, V_DONE);
                    push_plan(inst, t + 1, V_IDLE);
                end else begin
                    push_plan(inst, t, V_B);
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic [4:0] got, input logic [4:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end else begin
            $display("[TB] %s = %b ok", name, got);
        end
    endtask

    task automatic check_event(input int inst, input logic [4:0] vec);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change inst%0d: got outputs %b at cycle %0d, required no change",
                     inst, vec, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst[0] || e.vec != vec || e.cyc != cyc) begin
                fails++;
                $display("FAIL event inst%0d: got outputs %b at cycle %0d, required inst%0d outputs %b at cycle %0d",
                         inst, vec, cyc, e.inst, e.vec, e.cyc);
            end else begin
                $display("[TB] inst%0d outputs %b at cycle %0d ok", inst, vec, cyc);
            end
        end
    endtask

    task automatic drain_check(input string name);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One triggered run with ignored triggers sprinkled through the busy period
    task automatic do_run(input int inst, input bit hang);
        int ta, t_end, off, reps;
        reps = (inst == 0) ? 2 : 1;
        o_hang[inst] = hang;
        repeat ($urandom_range(15, 2)) @(negedge clk);
        trig[inst] = 1'b1;
        ta = cyc + 1;
        plan_run(inst, ta, reps, hang);
        t_end = plan_q[plan_q.size() - 1].cyc;
        foreach (plan_q[k]) exp_q.push_back(plan_q[k]);
        @(negedge clk);
        trig[inst] = 1'b0;
        while (cyc + 1 < t_end - 2) begin
            off = cyc + 1 - ta;
            trig[inst] = (off == LETTER_CYC + 10) ||
                         (off == LETTER_CYC + GAP_CYC + 20) ||
                         ($urandom_range(39, 0) == 0);
            @(negedge clk);
        end
        trig[inst] = 1'b0;
        drain_check(hang ? "run_watchdog" : "run_complete");
    endtask

    // Monitor: every change of a DUT output vector must match the next planned event
    initial begin
        logic [4:0] prev [2];
        prev[0] = 5'd0;
        prev[1] = 5'd0;
        @(posedge rstn);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (out_vec[i] !== prev[i]) begin
                    check_event(i, out_vec[i]);
                    prev[i] = out_vec[i];
                end
            end
        end
    end

    // Stimulus
    initial begin
        int ta;
        ev_t e;
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        o_hang[0] = 1'b0;
        o_hang[1] = 1'b0;
        repeat (4) @(negedge clk);
        check_val("reset_outputs_inst0", out_vec[0], V_IDLE);
        check_val("reset_outputs_inst1", out_vec[1], V_IDLE);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        do_run(0, 1'b0);
        do_run(0, 1'b0);
        do_run(0, 1'b1);
        do_run(0, 1'b0);

        // Reset in the middle of the second S letter
        repeat (3) @(negedge clk);
        trig[0] = 1'b1;
        ta = cyc + 1;
        plan_run(0, ta, 2, 1'b0);
        for (int k = 0; k < 5; k++) exp_q.push_back(plan_q[k]);
        @(negedge clk);
        trig[0] = 1'b0;
        for (int i = 0; i < 400 && cyc < ta + 2 * LETTER_CYC + 2 * GAP_CYC + 20; i++) @(negedge clk);
        @(posedge clk);
        #2;
        e.inst = 1'b0;
        e.vec  = V_IDLE;
        e.cyc  = cyc;
        exp_q.push_back(e);
        rstn = 1'b0;
        #1;
        check_val("async_reset_outputs", out_vec[0], V_IDLE);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (80) @(negedge clk);
        drain_check("reset_mid_letter");

        do_run(0, 1'b0);
        do_run(1, 1'b0);
        do_run(1, 1'b0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "time limit");
    end

endmodule
